// File: rtl/mem_rsp_pkg.sv
// rtl/mem_rsp_pkg.sv - shared types and constants for the CPU memory responder
package mem_rsp_pkg;

  // One-hot transaction states.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    WAIT = 3'b010,
    RESP = 3'b100
  } state_t;

  localparam int          RD_LAT_W        = 4;
  localparam logic [15:0] LFSR_SEED       = 16'hACE1;
  localparam int          MAX_EXTRA_STALL = 8;

endpackage

// File: rtl/mem_rsp_lfsr.sv
// rtl/mem_rsp_lfsr.sv - 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) for stall injection
//   clk    in   clock
//   rst    in   synchronous active-high reset, reloads the seed
//   o_lfsr out  current LFSR state, advances every cycle
module mem_rsp_lfsr
  import mem_rsp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= LFSR_SEED;
    else     r_lfsr <= {r_lfsr[14:0], w_fb};
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - RAM-backed responder for CPU fetch and load/store valid-ack channels
//   Ports: clk, rst (sync active-high)
//     fetch : PC, Inst_Req_Valid -> Inst_Req_Ack ; Instruction, Inst_Valid <- Inst_Ack
//     data  : Address, MemWrite, Write_data, Write_strb, MemRead -> Mem_Req_Ack ;
//             Read_data, Read_data_Valid <- Read_data_Ack
//   Config macro: MEM_RANDOM_STALL_EN adds LFSR-driven ack gating and WAIT stalls.
module cpu_mem_responder
  import mem_rsp_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int RD_LAT   = 2,
  parameter     INIT_HEX = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        Inst_Req_Valid,
  output logic        Inst_Req_Ack,
  output logic [31:0] Instruction,
  output logic        Inst_Valid,
  input  logic        Inst_Ack,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  input  logic        MemRead,
  output logic        Mem_Req_Ack,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ack
);

  localparam logic [RD_LAT_W-1:0] LAT = RD_LAT_W'(RD_LAT);

  logic [31:0] r_mem [0:(2**ADDR_W)-1];

  state_t              r_state, w_state_nxt;
  logic [RD_LAT_W-1:0] r_cnt;
  logic [ADDR_W-1:0]   r_idx;
  logic                r_is_inst;
  logic [31:0]         r_instruction, r_read_data;
  logic                r_inst_valid, r_rd_valid;

  logic [ADDR_W-1:0] w_addr_idx, w_pc_idx;
  logic w_gate, w_stall;
  logic w_inst_ack, w_mem_ack, w_store, w_take, w_take_inst, w_capture, w_done;

  assign w_addr_idx = Address[ADDR_W+1:2];
  assign w_pc_idx   = PC[ADDR_W+1:2];

  logic w_unused;
  assign w_unused = ^{Address[31:ADDR_W+2], Address[1:0], PC[31:ADDR_W+2], PC[1:0]};

`ifdef MEM_RANDOM_STALL_EN
  logic [15:0] w_lfsr;
  logic [3:0]  r_extra;
  logic        w_unused_lfsr;

  mem_rsp_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .o_lfsr (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr[15:2];
  assign w_gate  = !rst && w_lfsr[0];
  // Extra WAIT cycles are capped so a transaction always completes.
  assign w_stall = w_lfsr[1] && (r_extra < 4'(MAX_EXTRA_STALL));

  always_ff @(posedge clk) begin
    if (rst)                              r_extra <= '0;
    else if (w_take)                      r_extra <= '0;
    else if (r_state == WAIT && w_stall)  r_extra <= r_extra + 4'd1;
  end
`else
  assign w_gate  = !rst;
  assign w_stall = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_inst_ack  = 1'b0;
    w_mem_ack   = 1'b0;
    w_store     = 1'b0;
    w_take      = 1'b0;
    w_take_inst = 1'b0;
    w_capture   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gate) begin
          // A store wins even when MemRead is raised with it; no read response follows.
          if (MemWrite) begin
            w_mem_ack = 1'b1;
            w_store   = 1'b1;
          end else if (MemRead) begin
            w_mem_ack   = 1'b1;
            w_take      = 1'b1;
            w_state_nxt = (RD_LAT == 0) ? RESP : WAIT;
          end else if (Inst_Req_Valid) begin
            w_inst_ack  = 1'b1;
            w_take      = 1'b1;
            w_take_inst = 1'b1;
            w_state_nxt = (RD_LAT == 0) ? RESP : WAIT;
          end
        end
      end
      WAIT: begin
        if (!w_stall && r_cnt <= 1) w_state_nxt = RESP;
      end
      RESP: begin
        // First RESP cycle loads the output register; the ack only counts once valid is up.
        if (!(r_inst_valid || r_rd_valid)) begin
          w_capture = 1'b1;
        end else if (r_is_inst ? Inst_Ack : Read_data_Ack) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_is_inst     <= 1'b0;
      r_instruction <= '0;
      r_read_data   <= '0;
      r_inst_valid  <= 1'b0;
      r_rd_valid    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_idx     <= w_take_inst ? w_pc_idx : w_addr_idx;
        r_is_inst <= w_take_inst;
        r_cnt     <= LAT;
      end else if (r_state == WAIT && !w_stall) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) begin
        if (r_is_inst) begin
          r_instruction <= r_mem[r_idx];
          r_inst_valid  <= 1'b1;
        end else begin
          r_read_data <= r_mem[r_idx];
          r_rd_valid  <= 1'b1;
        end
      end
      if (w_done) begin
        r_inst_valid <= 1'b0;
        r_rd_valid   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) begin
      for (int i = 0; i < 4; i++) begin
        if (Write_strb[i]) r_mem[w_addr_idx][8*i +: 8] <= Write_data[8*i +: 8];
      end
    end
  end

  assign Inst_Req_Ack    = w_inst_ack;
  assign Mem_Req_Ack     = w_mem_ack;
  assign Instruction     = r_instruction;
  assign Inst_Valid      = r_inst_valid;
  assign Read_data       = r_read_data;
  assign Read_data_Valid = r_rd_valid;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb/tb_cpu_mem_responder.sv - directed self-checking bench for cpu_mem_responder
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC, Address, Write_data;
  logic        Inst_Req_Valid, Inst_Ack, MemWrite, MemRead, Read_data_Ack;
  logic [3:0]  Write_strb;
  logic        Inst_Req_Ack, Inst_Valid, Mem_Req_Ack, Read_data_Valid;
  logic [31:0] Instruction, Read_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_mem_responder #(.ADDR_W(12), .RD_LAT(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .PC              (PC),
    .Inst_Req_Valid  (Inst_Req_Valid),
    .Inst_Req_Ack    (Inst_Req_Ack),
    .Instruction     (Instruction),
    .Inst_Valid      (Inst_Valid),
    .Inst_Ack        (Inst_Ack),
    .Address         (Address),
    .MemWrite        (MemWrite),
    .Write_data      (Write_data),
    .Write_strb      (Write_strb),
    .MemRead         (MemRead),
    .Mem_Req_Ack     (Mem_Req_Ack),
    .Read_data       (Read_data),
    .Read_data_Valid (Read_data_Valid),
    .Read_data_Ack   (Read_data_Ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input string tag);
    @(negedge clk);
    MemWrite = 1'b1; Address = a; Write_data = d; Write_strb = s;
    #1 chk({tag, "_ack"}, Mem_Req_Ack, 1);
    @(negedge clk);
    MemWrite = 1'b0; Write_strb = 4'h0;
  endtask

  // Accept at edge t; valid must still be low after t+2 and high after t+3.
  task automatic do_load(input logic [31:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    MemRead = 1'b1; Address = a;
    #1 chk({tag, "_ack"}, Mem_Req_Ack, 1);
    @(negedge clk);
    MemRead = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_early"}, Read_data_Valid, 0);
    @(negedge clk);
    chk({tag, "_valid"}, Read_data_Valid, 1);
    chk({tag, "_data"}, Read_data, exp);
    Read_data_Ack = 1'b1;
    @(negedge clk);
    Read_data_Ack = 1'b0;
    chk({tag, "_drop"}, Read_data_Valid, 0);
  endtask

  initial begin
    rst = 1'b1; PC = '0; Address = '0; Write_data = '0; Write_strb = '0;
    Inst_Req_Valid = 0; Inst_Ack = 0; MemWrite = 0; MemRead = 0; Read_data_Ack = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_inst_req_ack", Inst_Req_Ack, 0);
    chk("rst_mem_req_ack", Mem_Req_Ack, 0);
    chk("rst_inst_valid", Inst_Valid, 0);
    chk("rst_rd_valid", Read_data_Valid, 0);
    chk("rst_instruction", Instruction, 0);
    chk("rst_read_data", Read_data, 0);
    rst = 1'b0;

    // Fetch from RAM[0].
    do_store(32'h0, 32'h0000_0013, 4'hF, "st_ram0");
    @(negedge clk);
    Inst_Req_Valid = 1'b1; PC = 32'h0;
    #1 chk("f1_ack", Inst_Req_Ack, 1);
    @(negedge clk);
    Inst_Req_Valid = 1'b0;
    chk("f1_wait_valid", Inst_Valid, 0);
    repeat (2) @(negedge clk);
    chk("f1_early", Inst_Valid, 0);
    @(negedge clk);
    chk("f1_valid", Inst_Valid, 1);
    chk("f1_instr", Instruction, 32'h0000_0013);
    Inst_Ack = 1'b1;
    @(negedge clk);
    Inst_Ack = 1'b0;
    chk("f1_drop", Inst_Valid, 0);

    // Byte-enable store.
    do_store(32'h10, 32'h0, 4'hF, "st_clr4");
    do_store(32'h10, 32'hAABB_CCDD, 4'b0100, "st_b2");
    do_load(32'h10, 32'h00BB_0000, "ld_b2");
    do_store(32'h10, 32'h1122_3344, 4'b0001, "st_b0");
    do_load(32'h10, 32'h00BB_0044, "ld_b0");

    // Response held while Read_data_Ack is withheld; new requests ignored meanwhile.
    @(negedge clk);
    MemRead = 1'b1; Address = 32'h10;
    #1 chk("hold_ack", Mem_Req_Ack, 1);
    @(negedge clk);
    MemRead = 1'b0;
    repeat (3) @(negedge clk);
    MemRead = 1'b1; Inst_Req_Valid = 1'b1; PC = 32'h0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_valid", Read_data_Valid, 1);
      chk("hold_data", Read_data, 32'h00BB_0044);
      chk("hold_no_mem_ack", Mem_Req_Ack, 0);
      chk("hold_no_inst_ack", Inst_Req_Ack, 0);
      @(negedge clk);
    end
    MemRead = 1'b0; Inst_Req_Valid = 1'b0; Read_data_Ack = 1'b1;
    @(negedge clk);
    Read_data_Ack = 1'b0;
    chk("hold_drop", Read_data_Valid, 0);

    // Load beats a simultaneous fetch; fetch accepted once the load completes.
    @(negedge clk);
    MemRead = 1'b1; Address = 32'h10; Inst_Req_Valid = 1'b1; PC = 32'h0;
    #1;
    chk("prio_mem_ack", Mem_Req_Ack, 1);
    chk("prio_inst_ack", Inst_Req_Ack, 0);
    @(negedge clk);
    MemRead = 1'b0;
    repeat (3) @(negedge clk);
    chk("prio_rd_valid", Read_data_Valid, 1);
    chk("prio_rd_data", Read_data, 32'h00BB_0044);
    chk("prio_inst_ack_wait", Inst_Req_Ack, 0);
    Read_data_Ack = 1'b1;
    @(negedge clk);
    Read_data_Ack = 1'b0;
    #1;
    chk("prio_rd_drop", Read_data_Valid, 0);
    chk("prio_fetch_ack", Inst_Req_Ack, 1);
    @(negedge clk);
    Inst_Req_Valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("prio_inst_valid", Inst_Valid, 1);
    chk("prio_instr", Instruction, 32'h0000_0013);
    Inst_Ack = 1'b1;
    @(negedge clk);
    Inst_Ack = 1'b0;
    chk("prio_inst_drop", Inst_Valid, 0);

    // Address wrap, with Read_data_Ack held high from before the response.
    do_store(32'h8, 32'h1234_5678, 4'hF, "st_ram2");
    @(negedge clk);
    MemRead = 1'b1; Address = 32'h0000_4008; Read_data_Ack = 1'b1;
    #1 chk("wrap_ack", Mem_Req_Ack, 1);
    @(negedge clk);
    MemRead = 1'b0;
    repeat (2) @(negedge clk);
    chk("wrap_early", Read_data_Valid, 0);
    @(negedge clk);
    chk("wrap_valid", Read_data_Valid, 1);
    chk("wrap_data", Read_data, 32'h1234_5678);
    @(negedge clk);
    Read_data_Ack = 1'b0;
    chk("wrap_drop", Read_data_Valid, 0);

    // Reset in WAIT abandons the load; RAM keeps its contents.
    do_store(32'h14, 32'hCAFE_F00D, 4'hF, "st_ram5");
    @(negedge clk);
    MemRead = 1'b1; Address = 32'h14;
    #1 chk("rstw_ack", Mem_Req_Ack, 1);
    @(negedge clk);
    MemRead = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rstw_valid", Read_data_Valid, 0);
    chk("rstw_data", Read_data, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstw_no_resp", Read_data_Valid, 0);
    do_load(32'h14, 32'hCAFE_F00D, "rstw_ld5");
    do_load(32'h8, 32'h1234_5678, "rstw_ld2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
